// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divide sequencer: state encoding and
// parameter helper functions.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ITER  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Default watchdog budget: one step per quotient bit, plus the cycle that
    // sees dp_done, plus one cycle of slack.
    function automatic int wdog_default(input int data_width);
        return data_width + 2;
    endfunction

    // Number of bits needed to hold values 0..value.
    function automatic int bits_for(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) begin
            w++;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/divider_controller.sv
// Sequencing FSM for the restoring-divide datapath of the multi-cycle ALU.
// Takes an operand pair over valid/ready, screens divide-by-zero, walks the
// datapath one step per cycle and returns the quotient over valid/ready.
// Abort and the watchdog drain or abandon the datapath cleanly.
module divider_controller
    import div_pkg::*;
#(
    parameter int DATA_WIDTH    = 6,
    parameter int COUNTER_WIDTH = 3,
    parameter int WDOG_LIMIT    = wdog_default(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] dp_Operand1,
    output logic [DATA_WIDTH-1:0] dp_Operand2,
    output logic                  initialize,
    output logic                  load_divident,
    output logic                  sh_en,
    input  logic                  dp_gt,
    input  logic                  dp_done,
    input  logic [DATA_WIDTH-1:0] dp_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_by_zero,
    output logic                  wdog_err,
    output logic                  busy
);

    // The watchdog must reach WDOG_LIMIT-1; it is also kept at least one bit
    // wider than the datapath step counter so it can always count past a
    // full divide.
    localparam int WDOG_W = max_int(bits_for(WDOG_LIMIT), COUNTER_WIDTH + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   op1_reg;
    logic [DATA_WIDTH-1:0]   op2_reg;
    logic [DATA_WIDTH-1:0]   quotient_reg;
    logic                    dbz_reg;
    logic                    wdog_err_reg;
    logic                    rsp_valid_reg;
    logic                    req_ready_reg;
    logic                    busy_reg;
    logic                    initialize_reg;
    logic [WDOG_W-1:0]       wdog_cnt_reg;

    // State register, watchdog, operand/response registers and the registered strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            op1_reg        <= '0;
            op2_reg        <= '0;
            quotient_reg   <= '0;
            dbz_reg        <= 1'b0;
            wdog_err_reg   <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            req_ready_reg  <= 1'b1;
            busy_reg       <= 1'b0;
            initialize_reg <= 1'b0;
            wdog_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        op1_reg       <= Operand1;
                        op2_reg       <= Operand2;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        wdog_err_reg  <= 1'b0;
                        if (Operand2 == '0) begin
                            // Answer immediately; the datapath is never touched.
                            quotient_reg  <= '1;
                            dbz_reg       <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= S_RESP;
                        end else begin
                            dbz_reg        <= 1'b0;
                            initialize_reg <= 1'b1;
                            wdog_cnt_reg   <= '0;
                            state_reg      <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    initialize_reg <= 1'b0;
                    if (abort) begin
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else begin
                        state_reg <= S_ITER;
                    end
                end
                S_ITER: begin
                    wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
                    if (dp_done) begin
                        quotient_reg  <= dp_result;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else if (wdog_cnt_reg == WDOG_LAST) begin
                        quotient_reg  <= '0;
                        wdog_err_reg  <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else if (abort) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    wdog_cnt_reg <= wdog_cnt_reg + WDOG_W'(1);
                    if (dp_done || (wdog_cnt_reg == WDOG_LAST)) begin
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg  <= 1'b0;
                    initialize_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= S_IDLE;
                end
            endcase
        end
    end

    // Step strobes follow this cycle's dp_gt/dp_done, so they are decoded
    // from the current state rather than registered.
    always_comb begin
        load_divident = 1'b0;
        sh_en         = 1'b0;
        if (!dp_done) begin
            if (state_reg == S_ITER) begin
                load_divident = dp_gt;
                sh_en         = ~dp_gt;
            end else if (state_reg == S_DRAIN) begin
                sh_en = 1'b1;
            end
        end
    end

    assign req_ready   = req_ready_reg;
    assign busy        = busy_reg;
    assign initialize  = initialize_reg;
    assign dp_Operand1 = op1_reg;
    assign dp_Operand2 = op2_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign quotient    = quotient_reg;
    assign div_by_zero = dbz_reg;
    assign wdog_err    = wdog_err_reg;

endmodule
